// File: rtl/msg_schdl_stream.sv
// Streaming SHA-2 message scheduler: a 16-word sliding window that emits one W[t] per
// output handshake. SHA_MODE selects SHA-256 (32b x 64 rounds) or SHA-512 (64b x 80 rounds).
module msg_schdl_stream #(
    parameter int unsigned SHA_MODE = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_msg_valid,
    output logic                                   o_msg_ready,
    input  logic [16*((SHA_MODE == 1) ? 64 : 32)-1:0] i_msg,
    input  logic                                   i_abort,
    output logic                                   o_w_valid,
    input  logic                                   i_w_ready,
    output logic [((SHA_MODE == 1) ? 64 : 32)-1:0]    o_w,
    output logic [6:0]                             o_w_idx,
    output logic                                   o_last,
    output logic                                   o_busy
);

    localparam int unsigned WORD_W  = (SHA_MODE == 1) ? 64 : 32;
    localparam int unsigned ROUNDS  = (SHA_MODE == 1) ? 80 : 64;
    localparam int unsigned MSG_SIZ = 16 * WORD_W;
    localparam int unsigned IDX_W   = 7;

    localparam int unsigned S0_RA = (SHA_MODE == 1) ? 1  : 7;
    localparam int unsigned S0_RB = (SHA_MODE == 1) ? 8  : 18;
    localparam int unsigned S0_SH = (SHA_MODE == 1) ? 7  : 3;
    localparam int unsigned S1_RA = (SHA_MODE == 1) ? 19 : 17;
    localparam int unsigned S1_RB = (SHA_MODE == 1) ? 61 : 19;
    localparam int unsigned S1_SH = (SHA_MODE == 1) ? 6  : 10;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic               ready_q;
    logic               valid_q;
    logic               last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  win_q [16];

    logic [WORD_W-1:0]  sig0;
    logic [WORD_W-1:0]  sig1;
    logic [WORD_W-1:0]  w_new;
    logic               tail;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    always_comb begin
        sig0  = rotr(win_q[1], S0_RA) ^ rotr(win_q[1], S0_RB) ^ (win_q[1] >> S0_SH);
        sig1  = rotr(win_q[14], S1_RA) ^ rotr(win_q[14], S1_RB) ^ (win_q[14] >> S1_SH);
        w_new = sig1 + win_q[9] + sig0 + win_q[0];
        // Words beyond W[ROUNDS-1] are never emitted, so the window drains with zeros.
        tail  = idx_q >= IDX_W'(ROUNDS - 16);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            for (int k = 0; k < 16; k++) win_q[k] <= '0;
        end else if (i_abort) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            for (int k = 0; k < 16; k++) win_q[k] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (i_msg_valid && ready_q) begin
                        for (int k = 0; k < 16; k++) begin
                            win_q[k] <= i_msg[MSG_SIZ-1-k*WORD_W -: WORD_W];
                        end
                        idx_q   <= '0;
                        state_q <= StRun;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (valid_q && i_w_ready) begin
                        for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
                        win_q[15] <= tail ? '0 : w_new;
                        if (idx_q == IDX_W'(ROUNDS - 1)) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            last_q <= (idx_q == IDX_W'(ROUNDS - 2));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_msg_ready = ready_q;
    assign o_w_valid   = valid_q;
    assign o_w         = win_q[0];
    assign o_w_idx     = idx_q;
    assign o_last      = last_q;
    assign o_busy      = (state_q == StRun);

endmodule
